// File: rtl/complex_nr_mult_core_if.sv
// ----------------------------------------------------------------------------
// complex_nr_mult_core_if
// Operand/result handshake bundle for the complex multiplier core.
//
// Parameter:
//   DATA_WIDTH : width of each signed operand component
//
// Signals:
//   op_val    producer -> core   operand valid
//   op_ready  core -> producer   core can accept operands
//   op_data   producer -> core   {op1_re, op1_im, op2_re, op2_im}, MSB first
//   op_conj   producer -> core   multiply by conj(op2) (COMPLEX_MULT_CONJ_EN only)
//   res_val   core -> consumer   result valid
//   res_ready consumer -> core   consumer takes the result
//   res_data  core -> consumer   {res_re, res_im}, each 2*DATA_WIDTH+1 bits
//
// Modports: master = producer/consumer side, slave = multiplier core.
// ----------------------------------------------------------------------------
interface complex_nr_mult_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      op_val;
  logic                      op_ready;
  logic [4*DATA_WIDTH-1:0]   op_data;
  logic                      res_val;
  logic                      res_ready;
  logic [4*DATA_WIDTH+1:0]   res_data;
`ifdef COMPLEX_MULT_CONJ_EN
  logic                      op_conj;
`endif

  modport master (
    output op_val,
    output op_data,
`ifdef COMPLEX_MULT_CONJ_EN
    output op_conj,
`endif
    input  op_ready,
    input  res_val,
    input  res_data,
    output res_ready
  );

  modport slave (
    input  op_val,
    input  op_data,
`ifdef COMPLEX_MULT_CONJ_EN
    input  op_conj,
`endif
    output op_ready,
    output res_val,
    output res_data,
    input  res_ready
  );
endinterface

// File: rtl/complex_nr_mult_core.sv
// ----------------------------------------------------------------------------
// complex_nr_mult_core
// Responder side of the complex multiplier handshake. Captures two signed
// complex operands, forms the four partial products in one registered stage,
// combines them in a registered add/subtract stage and holds the result until
// the consumer takes it. One transaction every 4 cycles with res_ready high.
//
// Optional feature macro: COMPLEX_MULT_CONJ_EN
//   When defined, bus.op_conj is captured with the operands and selects
//   op1 * conj(op2) instead of op1 * op2.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous reset, active high
//   i_sw_rst  synchronous software reset, active high (wins over any handshake)
//   bus       complex_nr_mult_core_if.slave handshake bundle
//
// State table:
//   S_IDLE | op_ready=1, waiting for op_val; operands captured on accept
//   S_MULT | partial products ac, bd, ad, bc registered
//   S_ADD  | real/imag sums registered, res_val raised
//   S_DONE | res_val=1, result held until res_ready
// ----------------------------------------------------------------------------
module complex_nr_mult_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sw_rst,
  complex_nr_mult_core_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_capture;
  logic   w_mult_en;
  logic   w_add_en;

  logic signed [W-1:0]  r_a, r_b, r_c, r_d;
  logic signed [PW-1:0] r_ac, r_bd, r_ad, r_bc;
  logic signed [RW-1:0] r_res_re, r_res_im;
  logic                 r_op_ready;
  logic                 r_res_val;
`ifdef COMPLEX_MULT_CONJ_EN
  logic                 r_conj;
`endif

  // Operands sign-extended to product width so each multiply is a plain
  // PW x PW signed product whose low PW bits are the exact result.
  logic signed [PW-1:0] w_a_x, w_b_x, w_c_x, w_d_x;
  logic signed [PW-1:0] w_ac, w_bd, w_ad, w_bc;
  logic signed [RW-1:0] w_ac_x, w_bd_x, w_ad_x, w_bc_x;
  logic signed [RW-1:0] w_res_re, w_res_im;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (i_sw_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // op_ready is 1 exactly in S_IDLE, so op_val alone qualifies the accept.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_mult_en   = 1'b0;
    w_add_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.op_val) begin
          w_capture   = 1'b1;
          w_state_nxt = S_MULT;
        end
      end
      S_MULT: begin
        w_mult_en   = 1'b1;
        w_state_nxt = S_ADD;
      end
      S_ADD: begin
        w_add_en    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_a_x = {{W{r_a[W-1]}}, r_a};
  assign w_b_x = {{W{r_b[W-1]}}, r_b};
  assign w_c_x = {{W{r_c[W-1]}}, r_c};
  assign w_d_x = {{W{r_d[W-1]}}, r_d};

  assign w_ac = w_a_x * w_c_x;
  assign w_bd = w_b_x * w_d_x;
  assign w_ad = w_a_x * w_d_x;
  assign w_bc = w_b_x * w_c_x;

  assign w_ac_x = {r_ac[PW-1], r_ac};
  assign w_bd_x = {r_bd[PW-1], r_bd};
  assign w_ad_x = {r_ad[PW-1], r_ad};
  assign w_bc_x = {r_bc[PW-1], r_bc};

`ifdef COMPLEX_MULT_CONJ_EN
  assign w_res_re = r_conj ? (w_ac_x + w_bd_x) : (w_ac_x - w_bd_x);
  assign w_res_im = r_conj ? (w_bc_x - w_ad_x) : (w_ad_x + w_bc_x);
`else
  assign w_res_re = w_ac_x - w_bd_x;
  assign w_res_im = w_ad_x + w_bc_x;
`endif

  // Handshake flags are registered from the next state so they line up
  // with r_state without any decode on the output path.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_ac       <= '0;
      r_bd       <= '0;
      r_ad       <= '0;
      r_bc       <= '0;
      r_res_re   <= '0;
      r_res_im   <= '0;
      r_op_ready <= 1'b1;
      r_res_val  <= 1'b0;
`ifdef COMPLEX_MULT_CONJ_EN
      r_conj     <= 1'b0;
`endif
    end else if (i_sw_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_ac       <= '0;
      r_bd       <= '0;
      r_ad       <= '0;
      r_bc       <= '0;
      r_res_re   <= '0;
      r_res_im   <= '0;
      r_op_ready <= 1'b1;
      r_res_val  <= 1'b0;
`ifdef COMPLEX_MULT_CONJ_EN
      r_conj     <= 1'b0;
`endif
    end else begin
      r_op_ready <= (w_state_nxt == S_IDLE);
      r_res_val  <= (w_state_nxt == S_DONE);
      if (w_capture) begin
        {r_a, r_b, r_c, r_d} <= bus.op_data;
`ifdef COMPLEX_MULT_CONJ_EN
        r_conj <= bus.op_conj;
`endif
      end
      if (w_mult_en) begin
        r_ac <= w_ac;
        r_bd <= w_bd;
        r_ad <= w_ad;
        r_bc <= w_bc;
      end
      if (w_add_en) begin
        r_res_re <= w_res_re;
        r_res_im <= w_res_im;
      end
    end
  end

  assign bus.op_ready = r_op_ready;
  assign bus.res_val  = r_res_val;
  assign bus.res_data = {r_res_re, r_res_im};

endmodule

// File: tb/tb_complex_nr_mult_core.sv
module tb_complex_nr_mult_core;
  localparam int DW = 8;

  logic clk;
  logic rst;
  logic sw_rst;

  int n_cmp = 0;
  int n_err = 0;

  complex_nr_mult_core_if #(.DATA_WIDTH(DW)) bus ();

  complex_nr_mult_core #(.DATA_WIDTH(DW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sw_rst (sw_rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a, b, c, d;
    int exp_re, exp_im;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: textbook complex multiplication on plain integers.
  function automatic void ref_mult(input int a, b, c, d, input bit conj,
                                   output int re, output int im);
    if (conj) begin
      re = a * c + b * d;
      im = b * c - a * d;
    end else begin
      re = a * c - b * d;
      im = a * d + b * c;
    end
  endfunction

  function automatic logic [4*DW-1:0] pack(input int a, b, c, d);
    logic [4*DW-1:0] w;
    w = {a[DW-1:0], b[DW-1:0], c[DW-1:0], d[DW-1:0]};
    return w;
  endfunction

  function automatic int fld(input logic [4*DW-1:0] w, input int idx);
    logic signed [DW-1:0] t;
    t = w[(3-idx)*DW +: DW];
    return int'(t);
  endfunction

  function automatic int get_re();
    logic signed [2*DW:0] t;
    t = bus.res_data[4*DW+1 -: 2*DW+1];
    return int'(t);
  endfunction

  function automatic int get_im();
    logic signed [2*DW:0] t;
    t = bus.res_data[2*DW:0];
    return int'(t);
  endfunction

  // Called #1 after an edge with the core idle. Pulses op_val for one
  // accept edge, scrambles op_data afterwards, waits for res_val and
  // completes a single-cycle transfer.
  task automatic run_txn(input int a, b, c, d, output int got_re, output int got_im,
                         output int lat);
    bus.op_data = pack(a, b, c, d);
    bus.op_val  = 1'b1;
    @(posedge clk); #1;
    bus.op_val  = 1'b0;
    bus.op_data = $urandom;
    lat = 0;
    while (!bus.res_val && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got_re = get_re();
    got_im = get_im();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int re, im, lat, er, ei;
    int a, b, c, d;
    bit cj;
    logic [4*DW+1:0] held;
    logic [4*DW-1:0] dq[16];
    int nres;

    vecs[0] = '{a:   2, b:   3, c:   4, d:   2, exp_re:    2, exp_im:     16};
    vecs[1] = '{a:  -1, b:  -1, c:  -1, d:  -1, exp_re:    0, exp_im:      2};
    vecs[2] = '{a:-128, b:-128, c:-128, d:-128, exp_re:    0, exp_im:  32768};
    vecs[3] = '{a: 127, b:-128, c: 127, d:-128, exp_re: -255, exp_im: -32512};
    vecs[4] = '{a: 127, b: 127, c:-128, d:-128, exp_re:    0, exp_im: -32512};
    vecs[5] = '{a:   0, b:   0, c:   5, d:   7, exp_re:    0, exp_im:      0};

    rst = 1'b1;
    sw_rst = 1'b0;
    bus.op_val = 1'b0;
    bus.op_data = '0;
    bus.res_ready = 1'b0;
`ifdef COMPLEX_MULT_CONJ_EN
    bus.op_conj = 1'b0;
`endif

    #12;
    check("reset_op_ready", bus.op_ready, 1);
    check("reset_res_val", bus.res_val, 0);
    check("reset_res_data", bus.res_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, re, im, lat);
      check($sformatf("tbl%0d_re", i), re, vecs[i].exp_re);
      check($sformatf("tbl%0d_im", i), im, vecs[i].exp_im);
      check($sformatf("tbl%0d_latency", i), lat, 2);
      check($sformatf("tbl%0d_op_ready_after", i), bus.op_ready, 1);
      check($sformatf("tbl%0d_res_val_after", i), bus.res_val, 0);
      check($sformatf("tbl%0d_re_held", i), get_re(), vecs[i].exp_re);
    end

    // Randomized against the reference model
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      c = int'($urandom_range(0, 255)) - 128;
      d = int'($urandom_range(0, 255)) - 128;
      cj = 1'b0;
`ifdef COMPLEX_MULT_CONJ_EN
      cj = 1'($urandom_range(0, 1));
      bus.op_conj = cj;
`endif
      ref_mult(a, b, c, d, cj, er, ei);
      run_txn(a, b, c, d, re, im, lat);
      check($sformatf("rnd%0d_re", i), re, er);
      check($sformatf("rnd%0d_im", i), im, ei);
      check($sformatf("rnd%0d_latency", i), lat, 2);
    end
`ifdef COMPLEX_MULT_CONJ_EN
    bus.op_conj = 1'b1;
    run_txn(2, 3, 4, 2, re, im, lat);
    check("conj_re", re, 14);
    check("conj_im", im, 8);
    bus.op_conj = 1'b0;
`endif

    // Backpressure: result held for 10 cycles, op_val pulses ignored
    bus.op_data = pack(2, 3, 4, 2);
    bus.op_val = 1'b1;
    @(posedge clk); #1;
    bus.op_val = 1'b0;
    lat = 0;
    while (!bus.res_val && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 2);
    held = bus.res_data;
    check("bp_re", get_re(), 2);
    check("bp_im", get_im(), 16);
    for (int k = 0; k < 10; k++) begin
      bus.op_val = k[0];
      bus.op_data = $urandom;
      @(posedge clk); #1;
      check($sformatf("bp_res_val_c%0d", k), bus.res_val, 1);
      check($sformatf("bp_res_data_c%0d", k), bus.res_data, held);
      check($sformatf("bp_op_ready_c%0d", k), bus.op_ready, 0);
    end
    bus.op_val = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("bp_res_val_after", bus.res_val, 0);
    check("bp_op_ready_after", bus.op_ready, 1);
    check("bp_res_data_kept", bus.res_data, held);
    @(posedge clk); #1;
    check("bp_single_transfer", bus.res_val, 0);

    // Async reset while in ADD
    bus.op_data = pack(5, 6, 7, 8);
    bus.op_val = 1'b1;
    @(posedge clk); #1;
    bus.op_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_op_ready", bus.op_ready, 1);
    check("arst_res_val", bus.res_val, 0);
    check("arst_res_data", bus.res_data, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_stays_idle", bus.res_val, 0);
    run_txn(1, 1, 1, 1, re, im, lat);
    check("arst_next_re", re, 0);
    check("arst_next_im", im, 2);
    check("arst_next_latency", lat, 2);

    // Software reset while in DONE, overriding a pending transfer
    bus.op_data = pack(3, 3, 3, 3);
    bus.op_val = 1'b1;
    @(posedge clk); #1;
    bus.op_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("srst_pre_res_val", bus.res_val, 1);
    sw_rst = 1'b1;
    bus.res_ready = 1'b1;
    bus.op_val = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    bus.res_ready = 1'b0;
    bus.op_val = 1'b0;
    check("srst_res_val", bus.res_val, 0);
    check("srst_res_data", bus.res_data, 0);
    check("srst_op_ready", bus.op_ready, 1);
    run_txn(1, 1, 1, 1, re, im, lat);
    check("srst_next_re", re, 0);
    check("srst_next_im", im, 2);

    // Back-to-back: op_val held high, res_ready high. Captures expected at
    // cycles 0, 4, 8; each result is visible 3 cycles after its capture.
    bus.res_ready = 1'b1;
    nres = 0;
    for (int k = 0; k < 16; k++) begin
      dq[k] = $urandom;
      bus.op_data = dq[k];
      bus.op_val = (k <= 8);
      check($sformatf("b2b_op_ready_c%0d", k), bus.op_ready, ((k % 4) == 0) || (k >= 12));
      check($sformatf("b2b_res_val_c%0d", k), bus.res_val, ((k % 4) == 3) && (k < 12));
      if (bus.res_val && k >= 3) begin
        ref_mult(fld(dq[k-3], 0), fld(dq[k-3], 1), fld(dq[k-3], 2), fld(dq[k-3], 3),
                 1'b0, er, ei);
        check($sformatf("b2b_re_c%0d", k), get_re(), er);
        check($sformatf("b2b_im_c%0d", k), get_im(), ei);
        nres++;
      end
      @(posedge clk); #1;
    end
    bus.op_val = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_result_count", nres, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
